// File: rtl/palette_arbiter.sv
// Round-robin sharing of one combinational palette lookup, with a two-stage
// response pipeline whose second stage applies a frame-stepped fade brightness.
module palette_arbiter #(
    parameter int NREQ       = 3,
    parameter int STEP_TICKS = 4
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic [NREQ-1:0]     req,
    input  logic [4*NREQ-1:0]   req_index,
    output logic [NREQ-1:0]     gnt,
    output logic [3:0]          pal_index,
    input  logic [3:0]          pal_red,
    input  logic [3:0]          pal_green,
    input  logic [3:0]          pal_blue,
    output logic                rsp_valid,
    output logic [1:0]          rsp_id,
    output logic [3:0]          rsp_red,
    output logic [3:0]          rsp_green,
    output logic [3:0]          rsp_blue,
    input  logic                frame_tick,
    input  logic                fade_out_start,
    input  logic                fade_in_start,
    output logic                fade_busy,
    output logic [3:0]          fade_level
);

    typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} fade_state_t;

    fade_state_t fade_state;
    logic [3:0]  tick_cnt;
    logic [1:0]  rr_ptr;
    logic [1:0]  grant_id;
    logic        grant_any;

    logic        s1_valid;
    logic [1:0]  s1_id;
    logic [3:0]  s1_red;
    logic [3:0]  s1_green;
    logic [3:0]  s1_blue;

    // Product fits in 9 bits; keeping bits [7:4] maps level 15 to identity.
    function automatic logic [3:0] scale(input logic [3:0] c, input logic [3:0] lvl);
        logic [8:0] prod;
        prod = 9'(c) * (9'(lvl) + 9'd1);
        return prod[7:4];
    endfunction

    // Priority walks from rr_ptr upward; the first candidate with req set wins.
    // Grants are suppressed while reset is asserted.
    always_comb begin
        gnt       = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        pal_index = 4'd0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_any && Reset_n && req[i] &&
                    ((int'(rr_ptr) + k == i) || (int'(rr_ptr) + k == i + NREQ))) begin
                    gnt[i]    = 1'b1;
                    grant_id  = 2'(i);
                    grant_any = 1'b1;
                    pal_index = req_index[4*i +: 4];
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_ptr <= 2'd0;
        end else if (grant_any) begin
            rr_ptr <= (grant_id == 2'(NREQ-1)) ? 2'd0 : grant_id + 2'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid  <= 1'b0;
            s1_id     <= 2'd0;
            s1_red    <= 4'd0;
            s1_green  <= 4'd0;
            s1_blue   <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_id    <= 2'd0;
            rsp_red   <= 4'd0;
            rsp_green <= 4'd0;
            rsp_blue  <= 4'd0;
        end else begin
            s1_valid  <= grant_any;
            s1_id     <= grant_id;
            s1_red    <= pal_red;
            s1_green  <= pal_green;
            s1_blue   <= pal_blue;
            rsp_valid <= s1_valid;
            rsp_id    <= s1_id;
            rsp_red   <= scale(s1_red, fade_level);
            rsp_green <= scale(s1_green, fade_level);
            rsp_blue  <= scale(s1_blue, fade_level);
        end
    end

    // A fade_out_start pulse takes precedence even if it cannot start a fade.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fade_state <= IDLE;
            fade_busy  <= 1'b0;
            fade_level <= 4'd15;
            tick_cnt   <= 4'd0;
        end else begin
            case (fade_state)
                IDLE: begin
                    if (fade_out_start) begin
                        if (fade_level != 4'd0) begin
                            fade_state <= FADE_OUT;
                            fade_busy  <= 1'b1;
                            tick_cnt   <= 4'd0;
                        end
                    end else if (fade_in_start && fade_level != 4'd15) begin
                        fade_state <= FADE_IN;
                        fade_busy  <= 1'b1;
                        tick_cnt   <= 4'd0;
                    end
                end
                FADE_OUT: begin
                    if (frame_tick) begin
                        if (tick_cnt == 4'(STEP_TICKS-1)) begin
                            tick_cnt   <= 4'd0;
                            fade_level <= fade_level - 4'd1;
                            if (fade_level == 4'd1) begin
                                fade_state <= IDLE;
                                fade_busy  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                FADE_IN: begin
                    if (frame_tick) begin
                        if (tick_cnt == 4'(STEP_TICKS-1)) begin
                            tick_cnt   <= 4'd0;
                            fade_level <= fade_level + 4'd1;
                            if (fade_level == 4'd14) begin
                                fade_state <= IDLE;
                                fade_busy  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    fade_state <= IDLE;
                    fade_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_palette_arbiter.sv
// Directed bench for palette_arbiter: arbitration order, pipeline latency,
// fade scaling and async reset behaviour, with hand-computed expectations.
module tb_palette_arbiter;

    logic        Clk;
    logic        Reset_n;
    logic [2:0]  req;
    logic [11:0] req_index;
    logic [2:0]  gnt;
    logic [3:0]  pal_index;
    logic [3:0]  pal_red, pal_green, pal_blue;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_red, rsp_green, rsp_blue;
    logic        frame_tick;
    logic        fade_out_start, fade_in_start;
    logic        fade_busy;
    logic [3:0]  fade_level;

    int err_cnt = 0;
    int chk_cnt = 0;

    palette_arbiter #(.NREQ(3), .STEP_TICKS(4)) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .req            (req),
        .req_index      (req_index),
        .gnt            (gnt),
        .pal_index      (pal_index),
        .pal_red        (pal_red),
        .pal_green      (pal_green),
        .pal_blue       (pal_blue),
        .rsp_valid      (rsp_valid),
        .rsp_id         (rsp_id),
        .rsp_red        (rsp_red),
        .rsp_green      (rsp_green),
        .rsp_blue       (rsp_blue),
        .frame_tick     (frame_tick),
        .fade_out_start (fade_out_start),
        .fade_in_start  (fade_in_start),
        .fade_busy      (fade_busy),
        .fade_level     (fade_level)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Palette contents: entry 2 is {C,9,5}; others follow a simple pattern.
    function automatic logic [11:0] pal_entry(input logic [3:0] i);
        if (i == 4'd2) return 12'hC95;
        return {i, ~i, i + 4'd3};
    endfunction

    always_comb begin
        logic [11:0] e;
        e = pal_entry(pal_index);
        pal_red   = e[11:8];
        pal_green = e[7:4];
        pal_blue  = e[3:0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Holds frame_tick high for exactly n rising edges; enter and leave just after a negedge.
    task automatic ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) @(negedge Clk);
        frame_tick = 1'b0;
    endtask

    // Accept requester 0 at palette index 2 and check the response two edges later.
    task automatic probe(input string tag, input logic [11:0] exp_rgb);
        req       = 3'b001;
        req_index = 12'h952;
        @(negedge Clk);
        req = 3'b000;
        @(negedge Clk);
        #1;
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_rgb"}, 32'({rsp_red, rsp_green, rsp_blue}), 32'(exp_rgb));
    endtask

    logic [2:0]  exp_gnt [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [2:0]  skip_gnt [3] = '{3'b100, 3'b001, 3'b100};
    logic [3:0]  id_idx [3] = '{4'h2, 4'h5, 4'h9};

    initial begin
        logic [11:0] e;
        Reset_n        = 1'b0;
        req            = '0;
        req_index      = '0;
        frame_tick     = 1'b0;
        fade_out_start = 1'b0;
        fade_in_start  = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            req            = 3'($urandom);
            req_index      = 12'($urandom);
            frame_tick     = 1'($urandom);
            fade_out_start = 1'($urandom);
            fade_in_start  = 1'($urandom);
            #1;
            check("rst_gnt", 32'(gnt), 32'd0);
            check("rst_valid", 32'(rsp_valid), 32'd0);
            check("rst_level", 32'(fade_level), 32'd15);
            check("rst_busy", 32'(fade_busy), 32'd0);
        end
        @(negedge Clk);
        req = '0; req_index = '0; frame_tick = 1'b0;
        fade_out_start = 1'b0; fade_in_start = 1'b0;
        Reset_n = 1'b1;
        @(negedge Clk);

        // Single request: latency of exactly two edges
        req = 3'b001; req_index = 12'h952;
        #1;
        check("single_gnt", 32'(gnt), 32'b001);
        check("single_index", 32'(pal_index), 32'd2);
        @(negedge Clk);
        req = 3'b000;
        #1;
        check("single_t1_valid", 32'(rsp_valid), 32'd0);
        @(negedge Clk);
        #1;
        check("single_valid", 32'(rsp_valid), 32'd1);
        check("single_id", 32'(rsp_id), 32'd0);
        check("single_rgb", 32'({rsp_red, rsp_green, rsp_blue}), 32'h0C95);

        // Skip idle requester: rr_ptr is now 1, req=101
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            req = 3'b101;
            #1;
            check($sformatf("skip_gnt%0d", k), 32'(gnt), 32'(skip_gnt[k]));
        end
        @(negedge Clk);
        req = 3'b000;
        @(negedge Clk);

        // Contention: all three requesting for six cycles, rr_ptr back at 0
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            req = (k < 6) ? 3'b111 : 3'b000;
            #1;
            if (k < 6) check($sformatf("cont_gnt%0d", k), 32'(gnt), 32'(exp_gnt[k]));
            if (k < 2) begin
                check($sformatf("cont_novalid%0d", k), 32'(rsp_valid), 32'd0);
            end else begin
                e = pal_entry(id_idx[(k-2) % 3]);
                check($sformatf("cont_valid%0d", k), 32'(rsp_valid), 32'd1);
                check($sformatf("cont_id%0d", k), 32'(rsp_id), 32'((k-2) % 3));
                check($sformatf("cont_rgb%0d", k), 32'({rsp_red, rsp_green, rsp_blue}), 32'(e));
            end
        end
        @(negedge Clk);
        @(negedge Clk);

        // Fade out from 15
        fade_out_start = 1'b1;
        @(negedge Clk);
        fade_out_start = 1'b0;
        #1;
        check("fo_busy", 32'(fade_busy), 32'd1);
        check("fo_level_start", 32'(fade_level), 32'd15);
        ticks(3);
        check("fo_level_3t", 32'(fade_level), 32'd15);
        ticks(1);
        check("fo_level_4t", 32'(fade_level), 32'd14);
        ticks(28);
        check("fo_level_32t", 32'(fade_level), 32'd7);
        check("fo_busy_32t", 32'(fade_busy), 32'd1);
        probe("fo_l7", 12'h642);
        ticks(27);
        check("fo_level_59t", 32'(fade_level), 32'd1);
        check("fo_busy_59t", 32'(fade_busy), 32'd1);
        ticks(1);
        check("fo_level_60t", 32'(fade_level), 32'd0);
        check("fo_busy_60t", 32'(fade_busy), 32'd0);
        probe("fo_l0", 12'h000);
        fade_out_start = 1'b1;
        @(negedge Clk);
        fade_out_start = 1'b0;
        #1;
        check("fo_at0_busy", 32'(fade_busy), 32'd0);
        check("fo_at0_level", 32'(fade_level), 32'd0);

        // Fade back in to full
        fade_in_start = 1'b1;
        @(negedge Clk);
        fade_in_start = 1'b0;
        #1;
        check("fi_busy", 32'(fade_busy), 32'd1);
        ticks(60);
        check("fi_level", 32'(fade_level), 32'd15);
        check("fi_busy_end", 32'(fade_busy), 32'd0);
        probe("fi_l15", 12'hC95);

        // Both starts together: fade out wins; fade_in during fade ignored
        fade_out_start = 1'b1;
        fade_in_start  = 1'b1;
        @(negedge Clk);
        fade_out_start = 1'b0;
        fade_in_start  = 1'b0;
        #1;
        check("both_busy", 32'(fade_busy), 32'd1);
        ticks(4);
        check("both_level_4t", 32'(fade_level), 32'd14);
        fade_in_start = 1'b1;
        @(negedge Clk);
        fade_in_start = 1'b0;
        ticks(20);
        check("both_level_24t", 32'(fade_level), 32'd9);
        check("both_busy_24t", 32'(fade_busy), 32'd1);

        // Async reset with stage 1 holding a valid entry
        req = 3'b001; req_index = 12'h952;
        @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        req = 3'b000;
        #1;
        check("arst_level", 32'(fade_level), 32'd15);
        check("arst_busy", 32'(fade_busy), 32'd0);
        check("arst_valid", 32'(rsp_valid), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk);
            #1;
            check($sformatf("arst_drop%0d", k), 32'(rsp_valid), 32'd0);
        end
        check("arst_level_after", 32'(fade_level), 32'd15);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
